// File: rtl/morse_keyer_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_keyer_if
//  Description : Request/status bundle between a Morse keyer and its host.
//  Revision    : 1.0  initial release
// ============================================================================
interface morse_keyer_if #(
    parameter int NUM_CHARS = 8,
    parameter int CHAR_W    = 8,
    parameter int LEN_W     = 4
);
    logic [NUM_CHARS*CHAR_W-1:0] chars;
    logic [LEN_W-1:0]            len;
    logic [1:0]                  speed_sel;
    logic                        repeat_en;
    logic                        start;
    logic                        abort;
    logic                        key;
    logic                        busy;
    logic                        done;
    logic [LEN_W-1:0]            char_idx;
    logic                        err;

    modport master (
        output chars, len, speed_sel, repeat_en, start, abort,
        input  key, busy, done, char_idx, err
    );

    modport slave (
        input  chars, len, speed_sel, repeat_en, start, abort,
        output key, busy, done, char_idx, err
    );
endinterface
`default_nettype wire

// File: rtl/morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_keyer
//  Description : Snapshots a string of character codes and keys them out as
//                timed Morse on/off to a buzzer, with repeat and abort.
//  Revision    : 1.0  initial release
// ============================================================================
module morse_keyer #(
    parameter int NUM_CHARS = 8,
    parameter int CHAR_W    = 8,
    parameter int BASE_UNIT = 2**21,
    parameter int LEN_W     = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    morse_keyer_if.slave      bus
);
    localparam int c_CNT_W = $clog2(4*BASE_UNIT) + 1;
    localparam int c_IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MARK = 3'd2,
        S_EGAP = 3'd3,
        S_CGAP = 3'd4,
        S_WGAP = 3'd5
    } state_t;

    // pat[4] is the first element; 1 = dash
    typedef struct packed {
        logic       valid;
        logic       space;
        logic [2:0] nel;
        logic [4:0] pat;
    } sym_t;

    function automatic sym_t decode(input logic [CHAR_W-1:0] code);
        sym_t       s;
        logic [5:0] c6;
        logic       hi_zero;
        s       = '0;
        c6      = code[5:0];
        hi_zero = ((code >> 6) == '0);
        if (hi_zero && c6 == 6'h3F) begin
            s.space = 1'b1;
        end else if (hi_zero) begin
            s.valid = 1'b1;
            case (c6)
                6'h00: {s.nel, s.pat} = {3'd5, 5'b11111};
                6'h01: {s.nel, s.pat} = {3'd5, 5'b01111};
                6'h02: {s.nel, s.pat} = {3'd5, 5'b00111};
                6'h03: {s.nel, s.pat} = {3'd5, 5'b00011};
                6'h04: {s.nel, s.pat} = {3'd5, 5'b00001};
                6'h05: {s.nel, s.pat} = {3'd5, 5'b00000};
                6'h06: {s.nel, s.pat} = {3'd5, 5'b10000};
                6'h07: {s.nel, s.pat} = {3'd5, 5'b11000};
                6'h08: {s.nel, s.pat} = {3'd5, 5'b11100};
                6'h09: {s.nel, s.pat} = {3'd5, 5'b11110};
                6'h0A: {s.nel, s.pat} = {3'd2, 5'b01000};
                6'h0B: {s.nel, s.pat} = {3'd4, 5'b10000};
                6'h0C: {s.nel, s.pat} = {3'd4, 5'b10100};
                6'h0D: {s.nel, s.pat} = {3'd3, 5'b10000};
                6'h0E: {s.nel, s.pat} = {3'd1, 5'b00000};
                6'h0F: {s.nel, s.pat} = {3'd4, 5'b00100};
                6'h10: {s.nel, s.pat} = {3'd3, 5'b11000};
                6'h11: {s.nel, s.pat} = {3'd4, 5'b00000};
                6'h12: {s.nel, s.pat} = {3'd2, 5'b00000};
                6'h13: {s.nel, s.pat} = {3'd4, 5'b01110};
                6'h14: {s.nel, s.pat} = {3'd3, 5'b10100};
                6'h15: {s.nel, s.pat} = {3'd4, 5'b01000};
                6'h16: {s.nel, s.pat} = {3'd2, 5'b11000};
                6'h17: {s.nel, s.pat} = {3'd2, 5'b10000};
                6'h18: {s.nel, s.pat} = {3'd3, 5'b11100};
                6'h19: {s.nel, s.pat} = {3'd4, 5'b01100};
                6'h1A: {s.nel, s.pat} = {3'd4, 5'b11010};
                6'h1B: {s.nel, s.pat} = {3'd3, 5'b01000};
                6'h1C: {s.nel, s.pat} = {3'd3, 5'b00000};
                6'h1D: {s.nel, s.pat} = {3'd1, 5'b10000};
                6'h1E: {s.nel, s.pat} = {3'd3, 5'b00100};
                6'h1F: {s.nel, s.pat} = {3'd4, 5'b00010};
                6'h20: {s.nel, s.pat} = {3'd3, 5'b01100};
                6'h21: {s.nel, s.pat} = {3'd4, 5'b10010};
                6'h22: {s.nel, s.pat} = {3'd4, 5'b10110};
                6'h23: {s.nel, s.pat} = {3'd4, 5'b11000};
                default: s.valid = 1'b0;
            endcase
        end
        return s;
    endfunction

    state_t              r_state, w_nstate;
    logic [CHAR_W-1:0]   r_chars [NUM_CHARS];
    logic [LEN_W-1:0]    r_len;
    logic [c_CNT_W-1:0]  r_unit;
    logic                r_rep;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [LEN_W-1:0]    r_idx;
    logic [2:0]          r_elem;
    logic [2:0]          r_nel;
    logic [4:0]          r_pat;
    logic                r_key, r_busy, r_done, r_err;

    logic [LEN_W-1:0]    w_len_in;
    logic [c_CNT_W-1:0]  w_unit_shift, w_unit_in;
    logic [c_CNT_W-1:0]  w_d1, w_d3, w_d4;
    sym_t                w_sym;
    logic [LEN_W-1:0]    w_idx_next;
    logic [2:0]          w_elem_next;
    logic                w_cnt_load;
    logic [c_CNT_W-1:0]  w_cnt_val;
    logic                w_done, w_set_err, w_snap, w_sym_load, w_advance;

    assign w_len_in     = (bus.len > LEN_W'(NUM_CHARS)) ? LEN_W'(NUM_CHARS) : bus.len;
    assign w_unit_shift = c_CNT_W'(BASE_UNIT) >> bus.speed_sel;
    assign w_unit_in    = (w_unit_shift == '0) ? c_CNT_W'(1) : w_unit_shift;
    assign w_d1         = r_unit - c_CNT_W'(1);
    assign w_d3         = (r_unit << 1) + r_unit - c_CNT_W'(1);
    assign w_d4         = (r_unit << 2) - c_CNT_W'(1);
    assign w_sym        = decode(r_chars[r_idx[c_IDX_W-1:0]]);

    always_comb begin
        w_nstate    = r_state;
        w_idx_next  = r_idx;
        w_elem_next = r_elem;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_done      = 1'b0;
        w_set_err   = 1'b0;
        w_snap      = 1'b0;
        w_sym_load  = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_snap = 1'b1;
                    if (w_len_in == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_nstate   = S_LOAD;
                        w_idx_next = '0;
                    end
                end
            end
            S_LOAD: begin
                if (w_sym.valid) begin
                    w_nstate    = S_MARK;
                    w_sym_load  = 1'b1;
                    w_elem_next = '0;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = w_sym.pat[4] ? w_d3 : w_d1;
                end else if (w_sym.space) begin
                    w_nstate   = S_WGAP;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = w_d4;
                end else begin
                    w_set_err = 1'b1;
                    w_advance = 1'b1;
                end
            end
            S_MARK: begin
                if (r_cnt == '0) begin
                    w_cnt_load = 1'b1;
                    if ((r_elem + 3'd1) < r_nel) begin
                        w_nstate    = S_EGAP;
                        w_elem_next = r_elem + 3'd1;
                        w_cnt_val   = w_d1;
                    end else begin
                        w_nstate  = S_CGAP;
                        w_cnt_val = w_d3;
                    end
                end
            end
            S_EGAP: begin
                if (r_cnt == '0) begin
                    w_nstate   = S_MARK;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = r_pat[3'd4 - r_elem] ? w_d3 : w_d1;
                end
            end
            S_CGAP, S_WGAP: begin
                if (r_cnt == '0) w_advance = 1'b1;
            end
            default: w_nstate = S_IDLE;
        endcase

        // Zero-cycle slot step: straight into the next LOAD or back to IDLE
        if (w_advance) begin
            if ((r_idx + LEN_W'(1)) < r_len) begin
                w_idx_next = r_idx + LEN_W'(1);
                w_nstate   = S_LOAD;
            end else if (r_rep) begin
                w_idx_next = '0;
                w_nstate   = S_LOAD;
            end else begin
                w_idx_next = '0;
                w_done     = 1'b1;
                w_nstate   = S_IDLE;
            end
        end

        if (r_state != S_IDLE && bus.abort) begin
            w_nstate   = S_IDLE;
            w_idx_next = '0;
            w_done     = 1'b0;
            w_set_err  = 1'b0;
            w_cnt_load = 1'b0;
            w_sym_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_unit  <= c_CNT_W'(1);
            r_rep   <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_elem  <= '0;
            r_nel   <= '0;
            r_pat   <= '0;
            r_key   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_idx   <= w_idx_next;
            r_elem  <= w_elem_next;
            r_key   <= (w_nstate == S_MARK);
            r_busy  <= (w_nstate != S_IDLE);
            r_done  <= w_done;
            if (w_snap) begin
                r_len  <= w_len_in;
                r_unit <= w_unit_in;
                r_rep  <= bus.repeat_en;
            end
            if (w_sym_load) begin
                r_nel <= w_sym.nel;
                r_pat <= w_sym.pat;
            end
            if (w_cnt_load)
                r_cnt <= w_cnt_val;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_snap)
                r_err <= 1'b0;
            else if (w_set_err)
                r_err <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst)
                    r_chars[gi] <= '0;
                else if (w_snap)
                    r_chars[gi] <= bus.chars[gi*CHAR_W +: CHAR_W];
            end
        end
    endgenerate

    assign bus.key      = r_key;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.char_idx = r_idx;
    assign bus.err      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_keyer
//  Description : Scoreboard bench: expected key/done/err edges are queued at
//                start time and matched by an independent output monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_morse_keyer;
    localparam int c_NUM_CHARS = 4;
    localparam int c_CHAR_W    = 8;
    localparam int c_BASE_UNIT = 4;
    localparam int c_LEN_W     = 4;

    localparam int EV_ERR  = 0;
    localparam int EV_KON  = 1;
    localparam int EV_KOFF = 2;
    localparam int EV_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    morse_keyer_if #(.NUM_CHARS(c_NUM_CHARS), .CHAR_W(c_CHAR_W), .LEN_W(c_LEN_W)) bus ();

    morse_keyer #(
        .NUM_CHARS(c_NUM_CHARS),
        .CHAR_W   (c_CHAR_W),
        .BASE_UNIT(c_BASE_UNIT),
        .LEN_W    (c_LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t sb[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    int  T      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic got(int kind);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
        end else begin
            e = sb.pop_front();
            chk($sformatf("event_kind(exp %0d)", e.kind), kind, e.kind);
            chk($sformatf("event_cycle(kind %0d)", e.kind), cyc, e.at);
        end
    endtask

    logic pk = 1'b0;
    logic pe = 1'b0;
    always @(negedge clk) begin
        if (bus.err === 1'b1 && pe !== 1'b1) got(EV_ERR);
        if (bus.key === 1'b1 && pk !== 1'b1) got(EV_KON);
        if (bus.key !== 1'b1 && pk === 1'b1) got(EV_KOFF);
        if (bus.done === 1'b1) got(EV_DONE);
        pk <= bus.key;
        pe <= bus.err;
    end

    task automatic ex(int kind, int off);
        sb.push_back('{kind, T + off});
    endtask

    task automatic kick(logic [31:0] ch, int l, int sp, bit rp);
        @(posedge clk); #1;
        bus.chars     = ch;
        bus.len       = l[3:0];
        bus.speed_sel = sp[1:0];
        bus.repeat_en = rp;
        bus.start     = 1'b1;
        T             = cyc;
    endtask

    task automatic unkick;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic drive_to(int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_to(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain(string name, int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        bus.chars     = '0;
        bus.len       = 4'd1;
        bus.speed_sel = 2'd0;
        bus.repeat_en = 1'b0;

        // Reset held with start asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key", bus.key, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_idx", bus.char_idx, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);

        // 'E' at unit 4
        kick(32'h0000000E, 1, 0, 0);
        ex(EV_KON, 2); ex(EV_KOFF, 6); ex(EV_DONE, 18);
        unkick;
        chk("e_busy_t1", bus.busy, 1);
        chk("e_idx_t1", bus.char_idx, 0);
        chk("e_key_t1", bus.key, 0);
        check_to(T + 17);
        chk("e_busy_t17", bus.busy, 1);
        check_to(T + 18);
        chk("e_busy_t18", bus.busy, 0);
        drain("e_drain", 40);

        // '0': five dashes
        kick(32'h00000000, 1, 0, 0);
        ex(EV_KON, 2);  ex(EV_KOFF, 14);
        ex(EV_KON, 18); ex(EV_KOFF, 30);
        ex(EV_KON, 34); ex(EV_KOFF, 46);
        ex(EV_KON, 50); ex(EV_KOFF, 62);
        ex(EV_KON, 66); ex(EV_KOFF, 78);
        ex(EV_DONE, 90);
        unkick;
        drain("zero_drain", 150);

        // 'E' at speed 1 and speed 3 (unit clamps to 1)
        kick(32'h0000000E, 1, 1, 0);
        ex(EV_KON, 2); ex(EV_KOFF, 4); ex(EV_DONE, 10);
        unkick;
        drain("e_sp1_drain", 40);

        kick(32'h0000000E, 1, 3, 0);
        ex(EV_KON, 2); ex(EV_KOFF, 3); ex(EV_DONE, 6);
        unkick;
        drain("e_sp3_drain", 40);

        // 'A' (.-) and 'G' (--.) at unit 1
        kick(32'h0000000A, 1, 3, 0);
        ex(EV_KON, 2); ex(EV_KOFF, 3); ex(EV_KON, 4); ex(EV_KOFF, 7); ex(EV_DONE, 10);
        unkick;
        drain("a_drain", 40);

        kick(32'h00000010, 1, 3, 0);
        ex(EV_KON, 2);  ex(EV_KOFF, 5);
        ex(EV_KON, 6);  ex(EV_KOFF, 9);
        ex(EV_KON, 10); ex(EV_KOFF, 11);
        ex(EV_DONE, 14);
        unkick;
        drain("g_drain", 40);

        // len=15 clamps to four slots
        kick(32'h0E0E0E0E, 15, 3, 0);
        ex(EV_KON, 2);  ex(EV_KOFF, 3);
        ex(EV_KON, 7);  ex(EV_KOFF, 8);
        ex(EV_KON, 12); ex(EV_KOFF, 13);
        ex(EV_KON, 17); ex(EV_KOFF, 18);
        ex(EV_DONE, 21);
        unkick;
        drain("clamp_drain", 60);

        // len=0: immediate done, never busy
        kick(32'h0000000E, 0, 0, 0);
        ex(EV_DONE, 1);
        unkick;
        chk("len0_busy_t1", bus.busy, 0);
        check_to(T + 2);
        chk("len0_busy_t2", bus.busy, 0);
        drain("len0_drain", 10);

        // E, invalid, word space, E
        kick(32'h0E3F7F0E, 4, 0, 0);
        ex(EV_KON, 2); ex(EV_KOFF, 6); ex(EV_ERR, 19);
        ex(EV_KON, 37); ex(EV_KOFF, 41); ex(EV_DONE, 53);
        unkick;
        bus.chars = '0;
        check_to(T + 20);
        chk("mix_idx_t20", bus.char_idx, 2);
        chk("mix_err_t20", bus.err, 1);
        drain("mix_drain", 80);

        // start together with abort while idle: nothing happens, err untouched
        @(posedge clk); #1;
        bus.chars = 32'h0000000E;
        bus.len   = 4'd1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abst_busy", bus.busy, 0);
        chk("abst_err", bus.err, 1);
        repeat (3) @(negedge clk);
        chk("abst_busy_late", bus.busy, 0);

        // repeat E,invalid then abort in the second mark; start while busy ignored
        kick(32'h00007F0E, 2, 0, 1);
        ex(EV_KON, 2); ex(EV_KOFF, 6); ex(EV_ERR, 19); ex(EV_KON, 20); ex(EV_KOFF, 22);
        unkick;
        chk("rep_err_clr", bus.err, 0);
        bus.chars = '0;
        drive_to(T + 10);
        bus.start = 1'b1;
        drive_to(T + 11);
        bus.start = 1'b0;
        drive_to(T + 21);
        bus.abort = 1'b1;
        drive_to(T + 22);
        bus.abort = 1'b0;
        chk("abort_key", bus.key, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_idx", bus.char_idx, 0);
        chk("abort_err_held", bus.err, 1);
        drain("abort_drain", 10);
        repeat (40) @(negedge clk);
        chk("abort_still_idle", bus.busy, 0);

        // reset mid-transmission
        kick(32'h0000000E, 1, 0, 0);
        ex(EV_KON, 2); ex(EV_KOFF, 4);
        unkick;
        drive_to(T + 3);
        rst = 1'b1;
        drive_to(T + 4);
        rst = 1'b0;
        chk("mrst_key", bus.key, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_err", bus.err, 0);
        drain("mrst_drain", 10);
        repeat (30) @(negedge clk);
        chk("mrst_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
